// File: rtl/hazard_fwd_unit_if.sv
// ID-stage request and hazard/forwarding response bundle for hazard_fwd_unit.
// master = pipeline control side, slave = the hazard/forwarding unit.
interface hazard_fwd_unit_if #(
   parameter int unsigned REG_AW    = 5,
   parameter int unsigned NUM_SRC   = 2,
   parameter int unsigned FWD_DEPTH = 2,
   parameter int unsigned CNT_W     = 16
);
   localparam int unsigned SELW = $clog2(FWD_DEPTH + 1);

   logic                      id_valid_i;
   logic [NUM_SRC*REG_AW-1:0] id_rs_i;
   logic [NUM_SRC-1:0]        id_rs_used_i;
   logic [REG_AW-1:0]         id_rd_i;
   logic                      id_regwrite_i;
   logic                      id_memread_i;
   logic                      flush_i;
   logic                      stall_o;
   logic                      bubble_o;
   logic [NUM_SRC*SELW-1:0]   fwd_sel_o;
   logic [CNT_W-1:0]          stall_cnt_o;

   modport master (
      output id_valid_i, id_rs_i, id_rs_used_i, id_rd_i, id_regwrite_i, id_memread_i, flush_i,
      input  stall_o, bubble_o, fwd_sel_o, stall_cnt_o
   );

   modport slave (
      input  id_valid_i, id_rs_i, id_rs_used_i, id_rd_i, id_regwrite_i, id_memread_i, flush_i,
      output stall_o, bubble_o, fwd_sel_o, stall_cnt_o
   );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller: shadow pipeline of destination tags drives EX forwarding
// selects and load-use stalls for the instruction in ID.
module hazard_fwd_unit #(
   parameter int unsigned REG_AW       = 5,
   parameter int unsigned NUM_SRC      = 2,
   parameter int unsigned FWD_DEPTH    = 2,
   parameter int unsigned LOAD_FWD_MIN = 2,
   parameter int unsigned CNT_W        = 16
) (
   input logic               clk_i,
   input logic               rst_i,
   hazard_fwd_unit_if.slave  bus
);
   localparam int unsigned SELW = $clog2(FWD_DEPTH + 1);

   // Slot 0 is EX, slot j is the j-th stage after EX.
   logic [FWD_DEPTH:0]        valid_q;
   logic [FWD_DEPTH:0]        regwrite_q;
   logic [FWD_DEPTH:0]        memread_q;
   logic [REG_AW-1:0]         rd_q [FWD_DEPTH+1];
   logic [NUM_SRC*REG_AW-1:0] rs_q;
   logic [NUM_SRC-1:0]        rs_used_q;
   logic [CNT_W-1:0]          cnt_q, cnt_d;

   logic                      stall;
   logic                      issue;
   logic [NUM_SRC*SELW-1:0]   fwd_sel;

   // Stall while a load still too young to forward produces a source the ID instruction reads.
   always_comb begin
      stall = 1'b0;
      for (int k = 0; k < int'(NUM_SRC); k++) begin
         for (int j = 0; j < int'(LOAD_FWD_MIN) - 1; j++) begin
            if (bus.id_rs_used_i[k] && valid_q[j] && regwrite_q[j] && memread_q[j] &&
                (rd_q[j] != '0) && (rd_q[j] == bus.id_rs_i[k*REG_AW +: REG_AW])) begin
               stall = 1'b1;
            end
         end
      end
      if (!bus.id_valid_i || bus.flush_i) begin
         stall = 1'b0;
      end
   end

   // Scan oldest to youngest so the youngest producer overwrites the select last.
   always_comb begin
      fwd_sel = '0;
      for (int k = 0; k < int'(NUM_SRC); k++) begin
         for (int j = int'(FWD_DEPTH); j >= 1; j--) begin
            if (valid_q[0] && rs_used_q[k] && valid_q[j] && regwrite_q[j] && (rd_q[j] != '0) &&
                (rd_q[j] == rs_q[k*REG_AW +: REG_AW])) begin
               fwd_sel[k*SELW +: SELW] = SELW'(j);
            end
         end
      end
   end

   assign issue = bus.id_valid_i & ~stall & ~bus.flush_i;

   always_comb begin
      cnt_d = cnt_q;
      if (stall && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q    <= '0;
         regwrite_q <= '0;
         memread_q  <= '0;
         for (int j = 0; j <= int'(FWD_DEPTH); j++) begin
            rd_q[j] <= '0;
         end
         rs_q       <= '0;
         rs_used_q  <= '0;
         cnt_q      <= '0;
      end else begin
         valid_q    <= {valid_q[FWD_DEPTH-1:0], issue};
         regwrite_q <= {regwrite_q[FWD_DEPTH-1:0], bus.id_regwrite_i};
         memread_q  <= {memread_q[FWD_DEPTH-1:0], bus.id_memread_i};
         for (int j = 1; j <= int'(FWD_DEPTH); j++) begin
            rd_q[j] <= rd_q[j-1];
         end
         rd_q[0]    <= bus.id_rd_i;
         rs_q       <= bus.id_rs_i;
         rs_used_q  <= bus.id_rs_used_i;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.stall_o     = stall;
   assign bus.bubble_o    = stall | bus.flush_i;
   assign bus.fwd_sel_o   = fwd_sel;
   assign bus.stall_cnt_o = cnt_q;
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit: directed pipeline scenarios plus random traffic,
// checked against an instruction-history model; a 2-bit-counter instance checks saturation.
module tb_hazard_fwd_unit;
   localparam int D   = 2;
   localparam int LFM = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hazard_fwd_unit_if #(.CNT_W(16)) bus ();
   hazard_fwd_unit_if #(.CNT_W(2))  bus2 ();

   assign bus2.id_valid_i    = bus.id_valid_i;
   assign bus2.id_rs_i       = bus.id_rs_i;
   assign bus2.id_rs_used_i  = bus.id_rs_used_i;
   assign bus2.id_rd_i       = bus.id_rd_i;
   assign bus2.id_regwrite_i = bus.id_regwrite_i;
   assign bus2.id_memread_i  = bus.id_memread_i;
   assign bus2.flush_i       = bus.flush_i;

   hazard_fwd_unit #(.CNT_W(16)) u_dut (.clk_i(clk), .rst_i(rst), .bus(bus));
   hazard_fwd_unit #(.CNT_W(2))  u_dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));

   // An issued instruction, tagged with the cycle it entered EX.
   typedef struct {
      int         e;
      logic [4:0] rs0;
      logic [4:0] rs1;
      logic [1:0] used;
      logic [4:0] rd;
      logic       rw;
      logic       mr;
   } instr_t;

   typedef struct {
      logic        stall;
      logic        bubble;
      logic [3:0]  fwd;
      logic [15:0] cnt;
      logic [1:0]  cnt2;
   } exp_t;

   instr_t hist[$];
   exp_t   sbq[$];
   int     cyc;
   int     m_cnt;
   int     checks;
   int     errors;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic int find(input int e);
      for (int i = 0; i < hist.size(); i++) begin
         if (hist[i].e == e) return i;
      end
      return -1;
   endfunction

   // Does the instruction that entered EX at cycle e write register a?
   function automatic bit prod(input int e, input logic [4:0] a, input bit want_load);
      int idx;
      idx = find(e);
      if (idx < 0) return 1'b0;
      return hist[idx].rw && (hist[idx].rd != 5'd0) && (hist[idx].rd == a) &&
             (!want_load || hist[idx].mr);
   endfunction

   task automatic step(input bit v, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [1:0] used, input logic [4:0] rd, input bit rw, input bit mr,
                       input bit fl, input bit rs, output bit st);
      exp_t       x;
      int         ex;
      int         f[2];
      logic [4:0] a;
      bus.id_valid_i    = v;
      bus.id_rs_i       = {r1, r0};
      bus.id_rs_used_i  = used;
      bus.id_rd_i       = rd;
      bus.id_regwrite_i = rw;
      bus.id_memread_i  = mr;
      bus.flush_i       = fl;
      rst               = rs;
      if (rs) begin
         hist.delete();
         m_cnt = 0;
      end
      st = 1'b0;
      if (v && !fl) begin
         for (int k = 0; k < 2; k++) begin
            a = (k == 1) ? r1 : r0;
            for (int j = 0; j <= LFM - 2; j++) begin
               if (used[k] && prod(cyc - j, a, 1'b1)) st = 1'b1;
            end
         end
      end
      f[0] = 0;
      f[1] = 0;
      ex = find(cyc);
      if (ex >= 0) begin
         for (int k = 0; k < 2; k++) begin
            a = (k == 1) ? hist[ex].rs1 : hist[ex].rs0;
            for (int j = D; j >= 1; j--) begin
               if (hist[ex].used[k] && prod(cyc - j, a, 1'b0)) f[k] = j;
            end
         end
      end
      x.stall  = st;
      x.bubble = st | fl;
      x.fwd    = {f[1][1:0], f[0][1:0]};
      x.cnt    = m_cnt[15:0];
      x.cnt2   = (m_cnt > 3) ? 2'd3 : m_cnt[1:0];
      sbq.push_back(x);
      @(posedge clk);
      cyc++;
      if (rs) begin
         hist.delete();
         m_cnt = 0;
      end else begin
         if (v && !st && !fl) begin
            hist.push_back('{e: cyc, rs0: r0, rs1: r1, used: used, rd: rd, rw: rw, mr: mr});
         end
         if (st && m_cnt < 65535) m_cnt++;
         while (hist.size() > 0 && hist[0].e < cyc - D) void'(hist.pop_front());
      end
      #1;
   endtask

   task automatic nop();
      bit st;
      step(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, st);
   endtask

   // Present an instruction in ID until it is accepted (bounded).
   task automatic issue(input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] used,
                        input logic [4:0] rd, input bit rw, input bit mr);
      bit st;
      st = 1'b1;
      for (int n = 0; n < 8 && st; n++) begin
         step(1'b1, r0, r1, used, rd, rw, mr, 1'b0, 1'b0, st);
      end
      if (st) begin
         checks++;
         errors++;
         $display("FAIL issue_bound at cycle %0d: still stalled, expected acceptance", cyc);
      end
   endtask

   // Monitor: outputs are valid every cycle; compare mid-cycle against the queued expectation.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            x = sbq.pop_front();
            chk("stall", 32'(bus.stall_o), 32'(x.stall));
            chk("bubble", 32'(bus.bubble_o), 32'(x.bubble));
            chk("fwd_sel", 32'(bus.fwd_sel_o), 32'(x.fwd));
            chk("stall_cnt", 32'(bus.stall_cnt_o), 32'(x.cnt));
            chk("stall_cnt_sat", 32'(bus2.stall_cnt_o), 32'(x.cnt2));
         end
      end
   end

   initial begin
      bit st;
      checks = 0;
      errors = 0;
      cyc    = 0;
      m_cnt  = 0;
      rst    = 1'b1;
      bus.id_valid_i    = 1'b0;
      bus.id_rs_i       = '0;
      bus.id_rs_used_i  = '0;
      bus.id_rd_i       = '0;
      bus.id_regwrite_i = 1'b0;
      bus.id_memread_i  = 1'b0;
      bus.flush_i       = 1'b0;
      @(posedge clk);
      #1;
      step(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, st);
      step(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, st);
      nop();
      // add r3; sub r4,r3,r3
      issue(5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0);
      issue(5'd3, 5'd3, 2'b11, 5'd4, 1'b1, 1'b0);
      nop(); nop();
      // add r3; add r3; or r6,r3 -> youngest; then with a NOP gap
      issue(5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0);
      issue(5'd2, 5'd1, 2'b11, 5'd3, 1'b1, 1'b0);
      issue(5'd3, 5'd0, 2'b01, 5'd6, 1'b1, 1'b0);
      nop(); nop();
      issue(5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0);
      nop();
      issue(5'd3, 5'd0, 2'b01, 5'd6, 1'b1, 1'b0);
      nop(); nop();
      // lw r5; add r7,r5,r0
      issue(5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1);
      issue(5'd5, 5'd0, 2'b01, 5'd7, 1'b1, 1'b0);
      nop(); nop();
      // r0 writes and unused sources
      issue(5'd1, 5'd0, 2'b01, 5'd0, 1'b1, 1'b0);
      issue(5'd0, 5'd0, 2'b11, 5'd8, 1'b1, 1'b0);
      issue(5'd1, 5'd0, 2'b01, 5'd0, 1'b1, 1'b1);
      issue(5'd0, 5'd0, 2'b11, 5'd8, 1'b1, 1'b0);
      issue(5'd1, 5'd0, 2'b01, 5'd9, 1'b1, 1'b1);
      issue(5'd9, 5'd9, 2'b00, 5'd8, 1'b1, 1'b0);
      nop(); nop();
      // lw r5; add r7,r5 flushed in the stall cycle
      issue(5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1);
      step(1'b1, 5'd5, 5'd0, 2'b01, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, st);
      nop(); nop();
      // repeated load-use pairs drive the 2-bit counter into saturation
      for (int i = 0; i < 5; i++) begin
         issue(5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1);
         issue(5'd0, 5'd5, 2'b10, 5'd7, 1'b1, 1'b0);
      end
      // reset mid-stall, then a clean issue
      issue(5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1);
      step(1'b1, 5'd5, 5'd0, 2'b01, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, st);
      step(1'b1, 5'd5, 5'd0, 2'b01, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, st);
      issue(5'd5, 5'd0, 2'b01, 5'd7, 1'b1, 1'b0);
      nop(); nop();
      // random traffic on a small register set to provoke hazards
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 299) == 0), st);
      end
      nop();
      @(negedge clk);
      #1;
      chk("scoreboard_drain", 32'(sbq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
